// File: rtl/acorn128_sequencer.sv
// Control sequencer for an ACORN-128 bit-serial datapath: walks INIT, AD, MSG and
// FINAL phases, selecting the m-bit source and ca/cb control bits for every step.
module acorn128_sequencer #(
   parameter int INIT_STEPS  = 1792,
   parameter int PAD_STEPS   = 256,
   parameter int FINAL_STEPS = 768
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_in,
   input  logic        decrypt_in,
   input  logic [7:0]  ad_len_in,
   input  logic [7:0]  msg_len_in,
   input  logic        dp_ready_in,
   input  logic        abort_in,
   output logic        step_en_out,
   output logic [2:0]  phase_out,
   output logic [10:0] bit_idx_out,
   output logic [2:0]  msrc_out,
   output logic        ca_out,
   output logic        cb_out,
   output logic        decrypt_out,
   output logic        tag_cap_out,
   output logic        busy_out,
   output logic        done_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      AD    = 3'd2,
      MSG   = 3'd3,
      FINAL = 3'd4,
      DONE  = 3'd5
   } phase_t;

   localparam logic [2:0] SRC_ZERO    = 3'd0;
   localparam logic [2:0] SRC_KEY     = 3'd1;
   localparam logic [2:0] SRC_IV      = 3'd2;
   localparam logic [2:0] SRC_KEY_INV = 3'd3;
   localparam logic [2:0] SRC_AD      = 3'd4;
   localparam logic [2:0] SRC_TEXT    = 3'd5;
   localparam logic [2:0] SRC_ONE     = 3'd6;

   phase_t      phase_q, phase_n;
   logic [10:0] idx_q, idx_n, last_idx;
   logic [7:0]  ad_len_q, ad_len_n, msg_len_q, msg_len_n;
   logic        dec_q, dec_n;
   logic [2:0]  msrc_q;
   logic        ca_q, cb_q, tag_q, busy_q, done_q;
   logic [5:0]  dec_bits;
   logic        active;

   // Per-step controls as a pure function of (phase, index, lengths): {msrc, ca, cb, tag}
   function automatic logic [5:0] decode(input phase_t ph, input logic [10:0] idx,
                                         input logic [7:0] adl, input logic [7:0] ml);
      logic [10:0] adw;
      logic [10:0] mw;
      logic [5:0]  r;
      adw = {3'b000, adl};
      mw  = {3'b000, ml};
      r   = 6'd0;
      case (ph)
         INIT: begin
            if (idx < 11'd128)       r[5:3] = SRC_KEY;
            else if (idx < 11'd256)  r[5:3] = SRC_IV;
            else if (idx == 11'd256) r[5:3] = SRC_KEY_INV;
            else                     r[5:3] = SRC_KEY;
            r[2:1] = 2'b11;
         end
         AD: begin
            if (idx < adw)       r[5:3] = SRC_AD;
            else if (idx == adw) r[5:3] = SRC_ONE;
            else                 r[5:3] = SRC_ZERO;
            r[2] = (idx < adw + 11'd128);
            r[1] = 1'b1;
         end
         MSG: begin
            if (idx < mw)       r[5:3] = SRC_TEXT;
            else if (idx == mw) r[5:3] = SRC_ONE;
            else                r[5:3] = SRC_ZERO;
            r[2] = 1'b1;
            r[1] = !(idx < mw + 11'd128);
         end
         FINAL: begin
            r[5:3] = SRC_ZERO;
            r[2:1] = 2'b11;
            r[0]   = (idx >= 11'(FINAL_STEPS - 128));
         end
         default: r = 6'd0;
      endcase
      return r;
   endfunction

   assign active      = (phase_q == INIT) || (phase_q == AD) || (phase_q == MSG) || (phase_q == FINAL);
   assign step_en_out = active && dp_ready_in && !abort_in;

   always_comb begin
      last_idx = 11'd0;
      case (phase_q)
         INIT:    last_idx = 11'(INIT_STEPS - 1);
         AD:      last_idx = {3'b000, ad_len_q} + 11'(PAD_STEPS - 1);
         MSG:     last_idx = {3'b000, msg_len_q} + 11'(PAD_STEPS - 1);
         FINAL:   last_idx = 11'(FINAL_STEPS - 1);
         default: last_idx = 11'd0;
      endcase
   end

   always_comb begin
      phase_n   = phase_q;
      idx_n     = idx_q;
      ad_len_n  = ad_len_q;
      msg_len_n = msg_len_q;
      dec_n     = dec_q;
      case (phase_q)
         IDLE: begin
            if (start_in) begin
               phase_n   = INIT;
               idx_n     = 11'd0;
               dec_n     = decrypt_in;
               ad_len_n  = (ad_len_in > 8'd128) ? 8'd128 : ad_len_in;
               msg_len_n = (msg_len_in > 8'd128) ? 8'd128 : msg_len_in;
            end
         end
         DONE: begin
            phase_n = IDLE;
            idx_n   = 11'd0;
         end
         default: begin
            if (abort_in) begin
               phase_n = IDLE;
               idx_n   = 11'd0;
            end else if (step_en_out) begin
               if (idx_q == last_idx) begin
                  idx_n = 11'd0;
                  case (phase_q)
                     INIT:    phase_n = AD;
                     AD:      phase_n = MSG;
                     MSG:     phase_n = FINAL;
                     default: phase_n = DONE;
                  endcase
               end else begin
                  idx_n = idx_q + 11'd1;
               end
            end
         end
      endcase
      dec_bits = decode(phase_n, idx_n, ad_len_n, msg_len_n);
   end

   // Controls are registered from the next state so they line up with phase/index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= IDLE;
         idx_q     <= 11'd0;
         ad_len_q  <= 8'd0;
         msg_len_q <= 8'd0;
         dec_q     <= 1'b0;
         msrc_q    <= SRC_ZERO;
         ca_q      <= 1'b0;
         cb_q      <= 1'b0;
         tag_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         phase_q   <= phase_n;
         idx_q     <= idx_n;
         ad_len_q  <= ad_len_n;
         msg_len_q <= msg_len_n;
         dec_q     <= dec_n;
         msrc_q    <= dec_bits[5:3];
         ca_q      <= dec_bits[2];
         cb_q      <= dec_bits[1];
         tag_q     <= dec_bits[0];
         busy_q    <= (phase_n != IDLE);
         done_q    <= (phase_n == DONE);
      end
   end

   assign phase_out   = phase_q;
   assign bit_idx_out = idx_q;
   assign msrc_out    = msrc_q;
   assign ca_out      = ca_q;
   assign cb_out      = cb_q;
   assign decrypt_out = dec_q;
   assign tag_cap_out = tag_q;
   assign busy_out    = busy_q;
   assign done_out    = done_q;

endmodule

// File: tb/tb_acorn128_sequencer.sv
// Bench for acorn128_sequencer: expected step list built from the phase rules,
// compared against the DUT every cycle, with random dp_ready stalls.
module tb_acorn128_sequencer;
   localparam int INIT_S  = 1792;
   localparam int PAD_S   = 256;
   localparam int FINAL_S = 768;

   logic        clk, rst, start_in, decrypt_in, dp_ready_in, abort_in;
   logic [7:0]  ad_len_in, msg_len_in;
   logic        step_en_out, ca_out, cb_out, decrypt_out, tag_cap_out, busy_out, done_out;
   logic [2:0]  phase_out, msrc_out;
   logic [10:0] bit_idx_out;

   acorn128_sequencer #(.INIT_STEPS(INIT_S), .PAD_STEPS(PAD_S), .FINAL_STEPS(FINAL_S)) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .decrypt_in(decrypt_in),
      .ad_len_in(ad_len_in), .msg_len_in(msg_len_in), .dp_ready_in(dp_ready_in),
      .abort_in(abort_in), .step_en_out(step_en_out), .phase_out(phase_out),
      .bit_idx_out(bit_idx_out), .msrc_out(msrc_out), .ca_out(ca_out), .cb_out(cb_out),
      .decrypt_out(decrypt_out), .tag_cap_out(tag_cap_out), .busy_out(busy_out),
      .done_out(done_out)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: one entry per expected step {phase, idx, msrc, ca, cb, tag}
   logic [19:0] exp_q[$];
   logic        exp_dec;
   int          exp_total;
   int          steps;
   int          post;
   bit          active = 1'b0;
   bit          op_over = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] pack(input int ph, input int idx, input int ms,
                                        input bit ca, input bit cb, input bit tag);
      return {3'(ph), 11'(idx), 3'(ms), ca, cb, tag};
   endfunction

   function automatic int clamp(input int v);
      return (v > 128) ? 128 : v;
   endfunction

   task automatic build_exp(input int ad, input int msg);
      int a, m, src;
      a = clamp(ad);
      m = clamp(msg);
      exp_q.delete();
      for (int i = 0; i < INIT_S; i++) begin
         src = (i < 128) ? 1 : (i < 256) ? 2 : (i == 256) ? 3 : 1;
         exp_q.push_back(pack(1, i, src, 1, 1, 0));
      end
      for (int i = 0; i < a + PAD_S; i++) begin
         src = (i < a) ? 4 : (i == a) ? 6 : 0;
         exp_q.push_back(pack(2, i, src, i < a + 128, 1, 0));
      end
      for (int i = 0; i < m + PAD_S; i++) begin
         src = (i < m) ? 5 : (i == m) ? 6 : 0;
         exp_q.push_back(pack(3, i, src, 1, !(i < m + 128), 0));
      end
      for (int i = 0; i < FINAL_S; i++)
         exp_q.push_back(pack(4, i, 0, 1, 1, i >= FINAL_S - 128));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, {phase_out, bit_idx_out, msrc_out, ca_out, cb_out, tag_cap_out}, 0);
      check({tag, "_flags"}, {step_en_out, decrypt_out, busy_out, done_out}, 0);
   endtask

   // compare process: every cycle of an operation, sampled on the falling edge
   always @(negedge clk) begin
      logic [19:0] e;
      logic        exp_step;
      if (active && !rst) begin
         if (post == 0) begin
            if (exp_q.size() == 0) begin
               check("queue_underflow", 1, 0);
               post = 2;
            end else begin
               e = exp_q[0];
               check("step_state", {phase_out, bit_idx_out, msrc_out, ca_out, cb_out, tag_cap_out}, e);
               check("busy", busy_out, 1);
               check("done_early", done_out, 0);
               check("decrypt", decrypt_out, exp_dec);
               exp_step = dp_ready_in && !abort_in;
               check("step_en", step_en_out, exp_step);
               if (abort_in) begin
                  exp_q.delete();
                  post = 2;
               end else if (exp_step) begin
                  void'(exp_q.pop_front());
                  steps++;
                  if (exp_q.size() == 0) post = 1;
               end
            end
         end else if (post == 1) begin
            check("done_phase", phase_out, 5);
            check("done_pulse", done_out, 1);
            check("done_busy", busy_out, 1);
            check("done_step_en", step_en_out, 0);
            check("step_count", steps, exp_total);
            post = 2;
         end else begin
            check("idle_state", {phase_out, bit_idx_out, msrc_out, ca_out, cb_out, tag_cap_out}, 0);
            check("idle_flags", {step_en_out, busy_out, done_out}, 0);
            active  = 1'b0;
            op_over = 1'b1;
         end
      end
   end

   // driver: runs one operation; abort_cyc / rst_cyc < 0 disables them
   task automatic run_op(input int ad, input int msg, input bit dec, input bit rnd,
                         input int abort_cyc, input int hold, input int rst_cyc);
      bit was_reset;
      was_reset = 1'b0;
      build_exp(ad, msg);
      exp_dec   = dec;
      exp_total = INIT_S + clamp(ad) + clamp(msg) + 2 * PAD_S + FINAL_S;
      steps     = 0;
      post      = 0;
      op_over   = 1'b0;
      ad_len_in = 8'(ad);
      msg_len_in = 8'(msg);
      decrypt_in = dec;
      start_in  = 1'b1;
      @(posedge clk);
      #1;
      active   = 1'b1;
      start_in = (hold > 0);
      dp_ready_in = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int c = 0; c < 20000 && !op_over; c++) begin
         if (c == abort_cyc) abort_in = 1'b1;
         if (c == rst_cyc) begin
            active = 1'b0;
            exp_q.delete();
            rst = 1'b1;
            #1;
            check_all_zero("mid_reset");
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            start_in = 1'b0;
            was_reset = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         abort_in = 1'b0;
         if (c + 1 >= hold) start_in = 1'b0;
         dp_ready_in = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (!op_over && !was_reset) begin
         check("timeout", 0, 1);
         active = 1'b0;
      end
      start_in = 1'b0;
      abort_in = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int tag_n, ad_n, a_rand, m_rand;

   initial begin
      rst = 1'b1;
      start_in = 1'b0; decrypt_in = 1'b1; dp_ready_in = 1'b1; abort_in = 1'b0;
      ad_len_in = 8'd0; msg_len_in = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // hand-computed pins on the model itself
      build_exp(128, 64);
      check("model_len_128_64", exp_q.size(), 3264);
      check("model_init_key0", exp_q[0][5:3], 1);
      check("model_init_iv128", exp_q[128][5:3], 2);
      check("model_init_kinv256", exp_q[256][5:3], 3);
      check("model_init_key257", exp_q[257][5:3], 1);
      check("model_ad_one", exp_q[1792 + 128][5:3], 6);
      check("model_ad_ca255", exp_q[1792 + 255][2], 1);
      check("model_ad_ca256", exp_q[1792 + 256][2], 0);
      check("model_msg_one", exp_q[1792 + 384 + 64][5:3], 6);
      check("model_msg_cb191", exp_q[1792 + 384 + 191][1], 0);
      check("model_msg_cb192", exp_q[1792 + 384 + 192][1], 1);
      tag_n = 0;
      foreach (exp_q[i]) if (exp_q[i][0]) tag_n++;
      check("model_tag_count", tag_n, 128);
      check("model_tag_first", exp_q[3264 - 128][16:6], 640);
      build_exp(0, 0);
      check("model_len_0_0", exp_q.size(), 3072);
      check("model_ad0_one", exp_q[1792][5:3], 6);
      check("model_msg0_one", exp_q[1792 + 256][5:3], 6);
      build_exp(200, 0);
      ad_n = 0;
      foreach (exp_q[i]) if (exp_q[i][19:17] == 3'd2) ad_n++;
      check("model_ad200_clamp", ad_n, 384);

      run_op(0, 0, 1'b0, 1'b0, -1, 0, -1);
      run_op(128, 64, 1'b1, 1'b1, -1, 0, -1);
      run_op(200, $urandom_range(0, 255), 1'b0, 1'b1, -1, 0, -1);
      a_rand = $urandom_range(0, 128);
      m_rand = $urandom_range(20, 128);
      run_op(a_rand, m_rand, 1'b1, 1'b0, INIT_S + a_rand + PAD_S + 10, 50, -1);
      run_op($urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1'b0, -1, 0, 500);
      run_op($urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b1, -1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
